// File: rtl/vga_text_ctrl.sv
// Text-mode controller: shares one character-RAM port between display fetch and host writes,
// tracks the cursor. Define VGA_TEXT_CURSOR_BLINK_EN to add the blinking CURSOR_HIT output.
module vga_text_ctrl #(
  parameter int unsigned       COLS       = 80,
  parameter int unsigned       ROWS       = 60,
  parameter int unsigned       ADDR_W     = 13,
  parameter int unsigned       CHAR_W     = 8,
  parameter logic [CHAR_W-1:0] BLANK_CHAR = 8'h20
) (
  input  logic              CLK,
  input  logic              RES,
  input  logic [9:0]        X,
  input  logic [9:0]        Y,
  input  logic              DISP,
  input  logic              WR_VALID,
  input  logic [CHAR_W-1:0] WR_CHAR,
  output logic              WR_READY,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic              RAM_WE,
  output logic [CHAR_W-1:0] RAM_WDATA,
  input  logic [CHAR_W-1:0] RAM_RDATA,
  output logic [CHAR_W-1:0] CHAR_OUT,
  output logic [6:0]        CUR_COL,
  output logic [5:0]        CUR_ROW,
  output logic              BUSY
`ifdef VGA_TEXT_CURSOR_BLINK_EN
  ,
  output logic              CURSOR_HIT
`endif
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StWrite   = 3'd1;
  localparam logic [2:0] StNewline = 3'd2;
  localparam logic [2:0] StBksp    = 3'd3;
  localparam logic [2:0] StErase   = 3'd4;
  localparam logic [2:0] StClear   = 3'd5;

  localparam logic [ADDR_W-1:0] LastCell = ADDR_W'(COLS * ROWS - 1);

  // row*80 + col as shift-add; the shifts assume COLS = 80
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [6:0] r, input logic [6:0] c);
    return (ADDR_W'(r) << 6) + (ADDR_W'(r) << 4) + ADDR_W'(c);
  endfunction

  logic [2:0]        state_q, state_d;
  logic [CHAR_W-1:0] char_q, char_d;
  logic [6:0]        col_q, col_d;
  logic [5:0]        row_q, row_d;
  logic [ADDR_W-1:0] clr_q, clr_d;
  logic              wr_ready_q, wr_ready_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [CHAR_W-1:0] wdata_q, wdata_d;
  logic [1:0]        rd_pipe_q;
  logic [CHAR_W-1:0] char_out_q;

  logic       disp_slot, handshake, last_col, last_row;
  logic [5:0] next_row;

  assign disp_slot = DISP && (X[2:0] == 3'd0);
  assign handshake = WR_VALID && wr_ready_q;
  assign last_col  = (col_q == 7'(COLS - 1));
  assign last_row  = (row_q == 6'(ROWS - 1));
  assign next_row  = last_row ? 6'd0 : row_q + 6'd1;

  always_comb begin
    state_d    = state_q;
    char_d     = char_q;
    col_d      = col_q;
    row_d      = row_q;
    clr_d      = clr_q;
    addr_d     = addr_q;
    we_d       = 1'b0;
    wdata_d    = wdata_q;
    case (state_q)
      StIdle: begin
        if (handshake) begin
          char_d = WR_CHAR;
          if (WR_CHAR >= CHAR_W'(8'h20) && WR_CHAR <= CHAR_W'(8'h7E)) state_d = StWrite;
          else if (WR_CHAR == CHAR_W'(8'h0A))                         state_d = StNewline;
          else if (WR_CHAR == CHAR_W'(8'h08))                         state_d = StBksp;
          else if (WR_CHAR == CHAR_W'(8'h0C))                         state_d = StClear;
          else                                                         state_d = StIdle;
        end
      end
      StWrite: begin
        if (!disp_slot) begin
          addr_d  = cell_addr({1'b0, row_q}, col_q);
          we_d    = 1'b1;
          wdata_d = char_q;
          if (last_col) begin
            col_d = 7'd0;
            row_d = next_row;
          end else begin
            col_d = col_q + 7'd1;
          end
          state_d = StIdle;
        end
      end
      StNewline: begin
        col_d   = 7'd0;
        row_d   = next_row;
        state_d = StIdle;
      end
      StBksp: begin
        if (col_q != 7'd0) begin
          col_d   = col_q - 7'd1;
          state_d = StErase;
        end else begin
          state_d = StIdle;
        end
      end
      StErase: begin
        if (!disp_slot) begin
          addr_d  = cell_addr({1'b0, row_q}, col_q);
          we_d    = 1'b1;
          wdata_d = BLANK_CHAR;
          state_d = StIdle;
        end
      end
      StClear: begin
        if (!disp_slot) begin
          addr_d  = clr_q;
          we_d    = 1'b1;
          wdata_d = BLANK_CHAR;
          if (clr_q == LastCell) begin
            clr_d   = '0;
            col_d   = 7'd0;
            row_d   = 6'd0;
            state_d = StIdle;
          end else begin
            clr_d = clr_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // Display fetch owns the port on its slot; writers above already held off
    if (disp_slot) begin
      addr_d = cell_addr(Y[9:3], X[9:3]);
      we_d   = 1'b0;
    end
    wr_ready_d = (state_d == StIdle) && !handshake;
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q    <= StIdle;
      char_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
      clr_q      <= '0;
      wr_ready_q <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      rd_pipe_q  <= '0;
      char_out_q <= '0;
    end else begin
      state_q    <= state_d;
      char_q     <= char_d;
      col_q      <= col_d;
      row_q      <= row_d;
      clr_q      <= clr_d;
      wr_ready_q <= wr_ready_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      rd_pipe_q  <= {rd_pipe_q[0], disp_slot};
      if (rd_pipe_q[1]) char_out_q <= RAM_RDATA;
    end
  end

  assign WR_READY  = wr_ready_q;
  assign RAM_ADDR  = addr_q;
  assign RAM_WE    = we_q;
  assign RAM_WDATA = wdata_q;
  assign CHAR_OUT  = char_out_q;
  assign CUR_COL   = col_q;
  assign CUR_ROW   = row_q;
  assign BUSY      = (state_q == StClear);

`ifdef VGA_TEXT_CURSOR_BLINK_EN
  logic [4:0] frame_q;
  logic [1:0] hit_pipe_q;
  logic       cursor_hit_q;
  logic       end_of_frame, cell_hit;

  assign end_of_frame = DISP && (X == 10'(COLS * 8 - 1)) && (Y == 10'(ROWS * 8 - 1));
  assign cell_hit     = disp_slot && (Y[9:3] == {1'b0, row_q}) && (X[9:3] == col_q) && frame_q[4];

  // Hit travels alongside the RAM read so it lines up with CHAR_OUT
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      frame_q      <= '0;
      hit_pipe_q   <= '0;
      cursor_hit_q <= 1'b0;
    end else begin
      if (end_of_frame) frame_q <= frame_q + 5'd1;
      hit_pipe_q <= {hit_pipe_q[0], cell_hit};
      if (rd_pipe_q[1]) cursor_hit_q <= hit_pipe_q[1];
    end
  end

  assign CURSOR_HIT = cursor_hit_q;
`else
  logic unused_y;
  assign unused_y = ^Y[2:0];
`endif

endmodule

// File: tb/tb_vga_text_ctrl.sv
// Directed bench for vga_text_ctrl with a 1-cycle-latency RAM model on the RAM port.
module tb_vga_text_ctrl;
  logic        CLK = 1'b0;
  logic        RES, DISP, WR_VALID, WR_READY, RAM_WE, BUSY;
  logic [9:0]  X, Y;
  logic [7:0]  WR_CHAR, RAM_WDATA, RAM_RDATA, CHAR_OUT;
  logic [12:0] RAM_ADDR;
  logic [6:0]  CUR_COL;
  logic [5:0]  CUR_ROW;

  logic        pre_we = 1'b0;
  logic [12:0] pre_addr = '0;
  logic [7:0]  pre_data = '0;
  logic [7:0]  mem [0:8191];

  int checks = 0;
  int failures = 0;

  vga_text_ctrl dut (
    .CLK(CLK), .RES(RES), .X(X), .Y(Y), .DISP(DISP),
    .WR_VALID(WR_VALID), .WR_CHAR(WR_CHAR), .WR_READY(WR_READY),
    .RAM_ADDR(RAM_ADDR), .RAM_WE(RAM_WE), .RAM_WDATA(RAM_WDATA), .RAM_RDATA(RAM_RDATA),
    .CHAR_OUT(CHAR_OUT), .CUR_COL(CUR_COL), .CUR_ROW(CUR_ROW), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (RAM_WE) mem[RAM_ADDR] <= RAM_WDATA;
    RAM_RDATA <= mem[RAM_ADDR];
  end

  // Called at a falling edge; returns at the falling edge after the handshake edge
  task automatic send_char(input logic [7:0] c);
    int n = 0;
    while (WR_READY !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (WR_READY !== 1'b1) begin
      checks++; failures++;
      $display("FAIL send_ready_timeout char=%02h got=%b exp=1", c, WR_READY);
    end
    WR_VALID = 1'b1;
    WR_CHAR  = c;
    @(negedge CLK);
    WR_VALID = 1'b0;
  endtask

  task automatic test_reset();
    RES = 1'b1; DISP = 1'b0; X = '0; Y = '0; WR_VALID = 1'b0; WR_CHAR = '0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({RAM_ADDR, RAM_WE, RAM_WDATA, CHAR_OUT, CUR_COL, CUR_ROW, WR_READY, BUSY} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got addr=%0d we=%b wd=%02h co=%02h col=%0d row=%0d rdy=%b busy=%b exp all 0",
               RAM_ADDR, RAM_WE, RAM_WDATA, CHAR_OUT, CUR_COL, CUR_ROW, WR_READY, BUSY);
    end
    RES = 1'b0;
    @(negedge CLK);
    checks++;
    if (WR_READY !== 1'b1) begin failures++; $display("FAIL reset_ready_rise got=%b exp=1", WR_READY); end
  endtask

  task automatic test_write_a();
    send_char(8'h41);
    checks++;
    if (RAM_WE !== 1'b0) begin failures++; $display("FAIL write_a_early_we got=%b exp=0", RAM_WE); end
    @(negedge CLK);
    checks++;
    if ({RAM_WE, RAM_ADDR, RAM_WDATA} !== {1'b1, 13'd0, 8'h41}) begin
      failures++;
      $display("FAIL write_a_port got we=%b addr=%0d wd=%02h exp we=1 addr=0 wd=41", RAM_WE, RAM_ADDR, RAM_WDATA);
    end
    checks++;
    if ({CUR_COL, CUR_ROW} !== {7'd1, 6'd0}) begin
      failures++; $display("FAIL write_a_cursor got col=%0d row=%0d exp col=1 row=0", CUR_COL, CUR_ROW);
    end
    @(negedge CLK);
    checks++;
    if (RAM_WE !== 1'b0) begin failures++; $display("FAIL write_a_one_cycle got we=%b exp=0", RAM_WE); end
  endtask

  task automatic test_slot_stall();
    pre_we = 1'b1; pre_addr = 13'd161; pre_data = 8'hC3;
    @(negedge CLK);
    pre_we = 1'b0;
    send_char(8'h42);
    DISP = 1'b1; X = 10'd8; Y = 10'd16;
    @(negedge CLK);
    checks++;
    if ({RAM_ADDR, RAM_WE} !== {13'd161, 1'b0}) begin
      failures++; $display("FAIL slot_read got addr=%0d we=%b exp addr=161 we=0", RAM_ADDR, RAM_WE);
    end
    DISP = 1'b0; X = 10'd9;
    @(negedge CLK);
    checks++;
    if ({RAM_WE, RAM_ADDR, RAM_WDATA, CUR_COL} !== {1'b1, 13'd1, 8'h42, 7'd2}) begin
      failures++;
      $display("FAIL slot_deferred_write got we=%b addr=%0d wd=%02h col=%0d exp we=1 addr=1 wd=42 col=2",
               RAM_WE, RAM_ADDR, RAM_WDATA, CUR_COL);
    end
    checks++;
    if (CHAR_OUT !== 8'h00) begin failures++; $display("FAIL slot_char_early got=%02h exp=00", CHAR_OUT); end
    @(negedge CLK);
    checks++;
    if (CHAR_OUT !== 8'hC3) begin failures++; $display("FAIL slot_char_out got=%02h exp=c3", CHAR_OUT); end
  endtask

  task automatic test_bksp();
    int nw;
    logic [12:0] wa;
    logic [7:0] wd;
    send_char(8'h0A);
    @(negedge CLK);
    checks++;
    if ({CUR_COL, CUR_ROW} !== {7'd0, 6'd1}) begin
      failures++; $display("FAIL newline_cursor got col=%0d row=%0d exp col=0 row=1", CUR_COL, CUR_ROW);
    end
    send_char(8'h08);
    nw = 0;
    for (int i = 0; i < 6; i++) begin
      if (RAM_WE === 1'b1) nw++;
      @(negedge CLK);
    end
    checks++;
    if (nw != 0 || {CUR_COL, CUR_ROW} !== {7'd0, 6'd1}) begin
      failures++;
      $display("FAIL bksp_col0 got writes=%0d col=%0d row=%0d exp writes=0 col=0 row=1", nw, CUR_COL, CUR_ROW);
    end
    send_char(8'h0A);
    for (int i = 0; i < 5; i++) send_char(8'h61 + 8'(i));
    send_char(8'h08);
    nw = 0; wa = '0; wd = '0;
    for (int i = 0; i < 6; i++) begin
      if (RAM_WE === 1'b1) begin nw++; wa = RAM_ADDR; wd = RAM_WDATA; end
      @(negedge CLK);
    end
    checks++;
    if (nw != 1 || wa !== 13'd164 || wd !== 8'h20) begin
      failures++;
      $display("FAIL bksp_write got writes=%0d addr=%0d wd=%02h exp writes=1 addr=164 wd=20", nw, wa, wd);
    end
    checks++;
    if ({CUR_COL, CUR_ROW} !== {7'd4, 6'd2}) begin
      failures++; $display("FAIL bksp_cursor got col=%0d row=%0d exp col=4 row=2", CUR_COL, CUR_ROW);
    end
  endtask

  task automatic test_ignored();
    int nw = 0;
    send_char(8'h01);
    checks++;
    if (WR_READY !== 1'b0) begin failures++; $display("FAIL ignored_ready_drop got=%b exp=0", WR_READY); end
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      if (RAM_WE === 1'b1) nw++;
    end
    checks++;
    if (nw != 0 || {CUR_COL, CUR_ROW, WR_READY} !== {7'd4, 6'd2, 1'b1}) begin
      failures++;
      $display("FAIL ignored_char got writes=%0d col=%0d row=%0d rdy=%b exp writes=0 col=4 row=2 rdy=1",
               nw, CUR_COL, CUR_ROW, WR_READY);
    end
  endtask

  task automatic test_wrap();
    int nw = 0;
    logic [12:0] wa = '0;
    logic [7:0] wd = '0;
    for (int i = 0; i < 57; i++) send_char(8'h0A);
    for (int i = 0; i < 79; i++) send_char(8'h2E);
    repeat (2) @(negedge CLK);
    checks++;
    if ({CUR_COL, CUR_ROW} !== {7'd79, 6'd59}) begin
      failures++; $display("FAIL wrap_setup got col=%0d row=%0d exp col=79 row=59", CUR_COL, CUR_ROW);
    end
    send_char(8'h5A);
    for (int i = 0; i < 4; i++) begin
      if (RAM_WE === 1'b1) begin nw++; wa = RAM_ADDR; wd = RAM_WDATA; end
      @(negedge CLK);
    end
    checks++;
    if (nw != 1 || wa !== 13'd4799 || wd !== 8'h5A) begin
      failures++;
      $display("FAIL wrap_write got writes=%0d addr=%0d wd=%02h exp writes=1 addr=4799 wd=5a", nw, wa, wd);
    end
    checks++;
    if ({CUR_COL, CUR_ROW} !== {7'd0, 6'd0}) begin
      failures++; $display("FAIL wrap_cursor got col=%0d row=%0d exp col=0 row=0", CUR_COL, CUR_ROW);
    end
  endtask

  task automatic test_clear();
    int nbusy = 0, nw = 0, nbad = 0;
    send_char(8'h0C);
    for (int i = 0; i < 4810; i++) begin
      if (BUSY === 1'b1) nbusy++;
      if (RAM_WE === 1'b1) begin
        if (RAM_ADDR !== 13'(nw) || RAM_WDATA !== 8'h20) nbad++;
        nw++;
      end
      @(negedge CLK);
    end
    checks++;
    if (nw != 4800 || nbad != 0) begin
      failures++; $display("FAIL clear_writes got writes=%0d bad=%0d exp writes=4800 bad=0", nw, nbad);
    end
    checks++;
    if (nbusy != 4800) begin failures++; $display("FAIL clear_busy_cycles got=%0d exp=4800", nbusy); end
    checks++;
    if ({WR_READY, BUSY, CUR_COL, CUR_ROW} !== {1'b1, 1'b0, 7'd0, 6'd0}) begin
      failures++;
      $display("FAIL clear_done got rdy=%b busy=%b col=%0d row=%0d exp rdy=1 busy=0 col=0 row=0",
               WR_READY, BUSY, CUR_COL, CUR_ROW);
    end
  endtask

  task automatic test_reset_mid_clear();
    int nw = 0;
    send_char(8'h51);
    send_char(8'h0C);
    for (int i = 0; i < 2000 && nw < 1000; i++) begin
      if (RAM_WE === 1'b1) nw++;
      if (nw < 1000) @(negedge CLK);
    end
    checks++;
    if (nw != 1000) begin failures++; $display("FAIL midclear_progress got=%0d exp=1000", nw); end
    RES = 1'b1;
    #1;
    checks++;
    if ({BUSY, CUR_COL, CUR_ROW, WR_READY, RAM_WE} !== '0) begin
      failures++;
      $display("FAIL midclear_abort got busy=%b col=%0d row=%0d rdy=%b we=%b exp all 0",
               BUSY, CUR_COL, CUR_ROW, WR_READY, RAM_WE);
    end
    @(negedge CLK);
    checks++;
    if (WR_READY !== 1'b0) begin failures++; $display("FAIL midclear_ready_held got=%b exp=0", WR_READY); end
    RES = 1'b0;
    @(negedge CLK);
    checks++;
    if ({WR_READY, BUSY} !== {1'b1, 1'b0}) begin
      failures++; $display("FAIL midclear_release got rdy=%b busy=%b exp rdy=1 busy=0", WR_READY, BUSY);
    end
  endtask

  initial begin
    test_reset();
    test_write_a();
    test_slot_stall();
    test_bksp();
    test_ignored();
    test_wrap();
    test_clear();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vga_text_ctrl.md
Name: vga_text_ctrl

Overview:
- Text-mode controller between the VGA timing generator (X, Y, DISP) and a single-port 80x60 character RAM (8x8 pixel cells).
- Shares the one RAM port between two users: display fetch (always wins) and a host character-write stream (valid/ready).
- Keeps the cursor and interprets control characters: newline, backspace, clear screen.
- CHAR_OUT feeds the downstream font ROM / pixel stage.

Parameters:
- COLS, 80, characters per row (H_VA/8)
- ROWS, 60, character rows (V_VA/8)
- ADDR_W, 13, RAM address width (covers COLS*ROWS = 4800)
- CHAR_W, 8, character code width
- BLANK_CHAR, 8'h20, fill code for clear and backspace

Ports:
- CLK  in  1  pixel clock (25 MHz, same as the timing generator's VGA_CLK)
- RES  in  1  asynchronous active-high reset
- X  in  10  pixel column from the timing generator
- Y  in  10  pixel row from the timing generator
- DISP  in  1  active-video flag from the timing generator
- WR_VALID  in  1  host presents WR_CHAR
- WR_CHAR  in  CHAR_W  host character code
- WR_READY  out  1  block can accept a character
- RAM_ADDR  out  ADDR_W  RAM address, registered
- RAM_WE  out  1  RAM write enable, registered
- RAM_WDATA  out  CHAR_W  RAM write data, registered
- RAM_RDATA  in  CHAR_W  RAM read data; synchronous RAM, 1-cycle latency
- CHAR_OUT  out  CHAR_W  character code for the current display cell
- CUR_COL  out  7  cursor column, 0..COLS-1
- CUR_ROW  out  6  cursor row, 0..ROWS-1
- BUSY  out  1  clear sweep in progress

Behaviour:
- Reset: every output is 0 (CUR_COL=0, CUR_ROW=0, WR_READY=0); state is IDLE. WR_READY rises on the first CLK edge after RES falls.
- Reset during an operation: the operation aborts immediately and the cursor returns to 0,0. RAM contents are not guaranteed.
- Display slot: the cycle when DISP=1 and X[2:0]=0.
  - On that edge: RAM_ADDR <= (Y>>3)*COLS + (X>>3) and RAM_WE <= 0.
  - The multiply is shift-add: (Y>>3)<<6 + (Y>>3)<<4.
  - Two edges after the slot edge, RAM_RDATA is captured into CHAR_OUT. CHAR_OUT is therefore valid 2 cycles after the slot; the pixel stage compensates.
  - The display slot always has priority.
- Writer slots: every other cycle. A pending write drives RAM_ADDR, RAM_WE=1 and RAM_WDATA for exactly one cycle.
  - If that cycle is a display slot, the write waits one cycle.
  - Never more than one stall in a row, since slots are 8 cycles apart.
- FSM states:
  - IDLE: WR_READY=1. A handshake (WR_VALID & WR_READY on an edge) latches WR_CHAR, sets WR_READY=0 and decodes:
    - 0x20..0x7E → WRITE
    - 0x0A → NEWLINE
    - 0x08 → BKSP
    - 0x0C → CLEAR
    - anything else → back to IDLE, consumed with no effect
  - WRITE: write char at row*COLS+col in the next writer slot. Then advance the cursor:
    - col+1;
    - at col=COLS-1: col=0, row+1;
    - at row=ROWS-1 and col=COLS-1: wrap to 0,0.
    - Then IDLE.
  - NEWLINE: col=0, row+1 (ROWS-1 wraps to 0). No RAM access. Lasts 1 cycle, then IDLE.
  - BKSP:
    - col>0: col-1, then write BLANK_CHAR at the new position, then IDLE.
    - col=0: no change, no write, IDLE.
  - CLEAR: BUSY=1. An internal address counter goes 0..COLS*ROWS-1, writing BLANK_CHAR once per writer slot. After the last cell: cursor 0,0, BUSY=0, IDLE.
- WR_READY returns to 1 on the edge the FSM re-enters IDLE. Back-to-back characters therefore need at least 2 cycles each.
- Display reads during a clear return whatever is in RAM at that moment (partially cleared screen is allowed).

Optional Feature:
- Macro: VGA_TEXT_CURSOR_BLINK_EN
- Defined:
  - Adds output CURSOR_HIT (1 bit, reset 0).
  - A 5-bit frame counter increments on the end-of-frame cycle: DISP=1, X=COLS*8-1, Y=ROWS*8-1.
  - CURSOR_HIT=1 when the displayed cell equals CUR_ROW,CUR_COL and counter[4]=1. It is aligned with CHAR_OUT (same 2-cycle latency).
- Undefined: no port, no counter.

Test Plan:
- Reset mid-CLEAR (RES pulse at cell 1000) → BUSY=0, CUR=0,0, WR_READY=0 while RES high and 1 the next cycle after release.
- Write 'A' (0x41) at reset cursor with DISP=0 → RAM_WE=1, RAM_ADDR=0, RAM_WDATA=0x41 for one cycle; CUR_COL=1.
- Cursor at col 79, row 59, write 'Z' → written at address 4799; cursor wraps to 0,0.
- Write request whose writer slot hits X=8, Y=16, DISP=1 → that cycle RAM_ADDR=161, RAM_WE=0; write happens the following cycle; CHAR_OUT shows RAM_RDATA 2 cycles after the slot.
- 0x08 at col 0 → no RAM write, cursor unchanged. 0x08 at col 5, row 2 → write 0x20 at address 164; CUR_COL=4.
- 0x0C with DISP=0 throughout → exactly 4800 writes of 0x20 to addresses 0..4799, BUSY high for 4800 cycles, then WR_READY=1.
